trail_ram_arbiter: RTL
======================

TRAIL_RAM_ARBITER -- requirements
Module: trail_ram_arbiter

Interface
REQ-001 Parameter BLOCO, default 8: side length in pixels of one trail block.
REQ-002 Parameter LARGURA, default 640: frame width and the address row stride.
REQ-003 Parameter ALTURA, default 480: frame height.
REQ-004 Parameters COR_J1 and COR_J2, defaults 8'h01 and 8'h80: RAM codes written for player 1 and player 2.
REQ-005 Port VGA_CLK, input, 1: the single clock, rising edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous and active-low.
REQ-007 Port clear_req, input, 1: request to zero the whole frame RAM (game restart).
REQ-008 Ports req_j1 and req_j2, input, 1 each: block-write request, held high until the matching ack.
REQ-009 Ports x_j1, y_j1, x_j2, y_j2, input, 10 each: top-left pixel of the requested block.
REQ-010 Ports ack_j1 and ack_j2, output, 1 each: one-cycle pulse when the request completes.
REQ-011 Ports colisao_j1 and colisao_j2, output, 1 each: collision result, valid only while the matching ack is high.
REQ-012 Port busy, output, 1: high in every state other than IDLE.
REQ-013 Ports ram_wraddress (19), ram_data (8) and ram_wren (1), output: RAM write port.
REQ-014 Port ram_rdaddress, output, 19: RAM check-read address.
REQ-015 Port ram_q, input, 8: RAM check-read data, with 2-cycle latency (address registered, output registered).

Function
REQ-016 FSM states SHALL be IDLE, LIMPA, LE, ESPERA, VERIFICA, ESCREVE and FIM; all outputs SHALL be registered.
REQ-017 A clear_req high in any cycle SHALL set clear_pend; clear_pend is acted on only in IDLE.
REQ-018 IDLE priority SHALL be: clear_pend, then player requests.
- Between req_j1 and req_j2, priority is round-robin on the last-served player.
- After reset, player 1 has priority.
REQ-019 Grant SHALL latch the player ID, x, y and the color, then go to LE.
REQ-020 LIMPA SHALL write 8'h00 to addresses 0 through LARGURA*ALTURA-1 (0 to 307199), one per cycle, then clear clear_pend and return to IDLE.
REQ-021 Requests arriving during LIMPA SHALL stay pending and be served afterwards.
REQ-022 Bounds check: if x > LARGURA-BLOCO or y > ALTURA-BLOCO, the request SHALL go straight to FIM with colisao=1 and no writes.
REQ-023 LE SHALL drive ram_rdaddress = y*LARGURA + x; ESPERA waits one cycle; VERIFICA samples ram_q.
REQ-024 A nonzero ram_q in VERIFICA SHALL set the collision flag and go to FIM without writing.
REQ-025 A zero ram_q in VERIFICA SHALL go to ESCREVE, which writes the color BLOCO*BLOCO times:
- address (y+r)*LARGURA + (x+c);
- c = 0..BLOCO-1 is the fastest index, then r = 0..BLOCO-1;
- one write per cycle with ram_wren high.
REQ-026 FIM SHALL pulse the granted ack for exactly one cycle, drive colisao, update the last-served player, and return to IDLE.
REQ-027 Cycle timing, counted from the grant edge (cycle 0):
- clean block: wren high in cycles 4 to 67, ack in cycle 68;
- collision: ack in cycle 4;
- out-of-bounds: ack in cycle 1.
REQ-028 ram_wren SHALL be 0 outside LIMPA and ESCREVE, and ram_wraddress SHALL never exceed 307199.
REQ-029 If both requests and clear_req are high in the same IDLE cycle, the clear SHALL run first.
REQ-030 A request dropped before its ack SHALL still complete its latched operation.

Reset
REQ-031 While reset_n is low, the block SHALL be in IDLE:
- all outputs 0;
- clear_pend 0;
- counters 0;
- last-served = player 2.
REQ-032 Reset mid-LIMPA or mid-ESCREVE SHALL abort at once, with ram_wren low on the same cycle; there is no resume.

Structure
REQ-033 A shared package SHALL hold:
- the FSM state encoding;
- the LARGURA/ALTURA/BLOCO defaults;
- the COR_J1/COR_J2 codes;
- the 19-bit address width.
REQ-034 One sub-module, trail_addr_gen, SHALL hold the row/column counters and compute row*LARGURA+col; it serves both LIMPA and ESCREVE.

Verification
REQ-035 After reset, clear_req pulse -> busy for 307200 writes of 00 covering addresses 0 to 307199, then busy=0.
REQ-036 req_j1 with (216,240) and ram_q=0:
- 64 writes of 8'h01, addresses 153816 to 153823 through 158296 to 158303;
- ack_j1 in cycle 68 with colisao_j1=0.
REQ-037 req_j2 with (100,50) and ram_q=8'h01 -> no writes; ack_j2 in cycle 4 with colisao_j2=1.
REQ-038 req_j1 and req_j2 held together:
- served in order j1, j2, j1 (round-robin);
- no write overlaps another.
REQ-039 req_j1 with (636,240) -> ack_j1 in cycle 1 with colisao_j1=1 and zero writes.
REQ-040 reset_n low at write 30 of an ESCREVE -> ram_wren=0 at once, state IDLE, no ack.

Source files
------------

// File: rtl/trail_ram_arbiter_pkg.sv
// Shared types and defaults for the trail RAM arbiter.
// Frame geometry, player colors and FSM encoding.
package trail_ram_arbiter_pkg;

  localparam int ADDR_W      = 19;
  localparam int LARGURA_DEF = 640;
  localparam int ALTURA_DEF  = 480;
  localparam int BLOCO_DEF   = 8;

  localparam logic [7:0] COR_J1_DEF = 8'h01;
  localparam logic [7:0] COR_J2_DEF = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    LIMPA,
    LE,
    ESPERA,
    VERIFICA,
    ESCREVE,
    FIM
  } state_t;

  typedef enum logic {
    J1 = 1'b0,
    J2 = 1'b1
  } player_t;

endpackage

// File: rtl/trail_addr_gen.sv
// Row/column walker producing row*LARGURA+col write addresses.
// Walks the full frame in clear mode, one block otherwise.
module trail_addr_gen
  import trail_ram_arbiter_pkg::*;
#(
  parameter int LARGURA = LARGURA_DEF,
  parameter int ALTURA  = ALTURA_DEF,
  parameter int BLOCO   = BLOCO_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              clear_mode,
  input  logic [9:0]        base_x,
  input  logic [9:0]        base_y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [9:0] col;
  logic [9:0] row;
  logic [9:0] col_max;
  logic [9:0] row_max;
  logic [ADDR_W-1:0] xx;
  logic [ADDR_W-1:0] yy;

  always_comb begin
    col_max = clear_mode ? 10'(LARGURA - 1) : 10'(BLOCO - 1);
    row_max = clear_mode ? 10'(ALTURA - 1) : 10'(BLOCO - 1);
    last    = (col == col_max) && (row == row_max);
  end

  always_comb begin
    xx   = ADDR_W'(base_x) + ADDR_W'(col);
    yy   = ADDR_W'(base_y) + ADDR_W'(row);
    addr = yy * ADDR_W'(LARGURA) + xx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col == col_max) begin
        col <= '0;
        row <= (row == row_max) ? '0 : row + 10'd1;
      end else begin
        col <= col + 10'd1;
      end
    end
  end

endmodule

// File: rtl/trail_ram_arbiter.sv
// Arbitrates two players' trail-block writes and frame clears
// onto one RAM, checking the block origin for a prior trail.
module trail_ram_arbiter
  import trail_ram_arbiter_pkg::*;
#(
  parameter int         BLOCO   = BLOCO_DEF,
  parameter int         LARGURA = LARGURA_DEF,
  parameter int         ALTURA  = ALTURA_DEF,
  parameter logic [7:0] COR_J1  = COR_J1_DEF,
  parameter logic [7:0] COR_J2  = COR_J2_DEF
) (
  input  logic              VGA_CLK,
  input  logic              reset_n,
  input  logic              clear_req,
  input  logic              req_j1,
  input  logic              req_j2,
  input  logic [9:0]        x_j1,
  input  logic [9:0]        y_j1,
  input  logic [9:0]        x_j2,
  input  logic [9:0]        y_j2,
  output logic              ack_j1,
  output logic              ack_j2,
  output logic              colisao_j1,
  output logic              colisao_j2,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_wraddress,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_rdaddress,
  input  logic [7:0]        ram_q
);

  localparam logic [9:0] X_MAX = 10'(LARGURA - BLOCO);
  localparam logic [9:0] Y_MAX = 10'(ALTURA - BLOCO);

  state_t            state;
  player_t           player;
  player_t           last_srv;
  logic              clear_pend;
  logic              col_flag;
  logic [9:0]        lat_x;
  logic [9:0]        lat_y;
  logic [7:0]        cor;

  logic              pick_j2;
  logic [9:0]        gx;
  logic [9:0]        gy;
  logic              oob;
  logic [ADDR_W-1:0] rd_addr;

  logic              ag_load;
  logic              ag_step;
  logic              ag_clr;
  logic [9:0]        ag_bx;
  logic [9:0]        ag_by;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_last;

  // Round-robin: player 2 wins a tie only if player 1 was served last.
  always_comb begin
    pick_j2 = req_j2 && (!req_j1 || last_srv == J1);
    gx      = pick_j2 ? x_j2 : x_j1;
    gy      = pick_j2 ? y_j2 : y_j1;
    oob     = (gx > X_MAX) || (gy > Y_MAX);
    rd_addr = ADDR_W'(gy) * ADDR_W'(LARGURA) + ADDR_W'(gx);
  end

  assign ag_load = (state == IDLE);
  assign ag_clr  = (state == LIMPA);
  assign ag_step = (state == LIMPA) || (state == ESCREVE);
  assign ag_bx   = ag_clr ? 10'd0 : lat_x;
  assign ag_by   = ag_clr ? 10'd0 : lat_y;

  trail_addr_gen #(
    .LARGURA(LARGURA),
    .ALTURA (ALTURA),
    .BLOCO  (BLOCO)
  ) u_addr (
    .clk       (VGA_CLK),
    .rst_n     (reset_n),
    .load      (ag_load),
    .step      (ag_step),
    .clear_mode(ag_clr),
    .base_x    (ag_bx),
    .base_y    (ag_by),
    .addr      (ag_addr),
    .last      (ag_last)
  );

  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      player        <= J1;
      last_srv      <= J2;
      clear_pend    <= 1'b0;
      col_flag      <= 1'b0;
      lat_x         <= '0;
      lat_y         <= '0;
      cor           <= '0;
      ack_j1        <= 1'b0;
      ack_j2        <= 1'b0;
      colisao_j1    <= 1'b0;
      colisao_j2    <= 1'b0;
      busy          <= 1'b0;
      ram_wraddress <= '0;
      ram_data      <= '0;
      ram_wren      <= 1'b0;
      ram_rdaddress <= '0;
    end else begin
      ack_j1     <= 1'b0;
      ack_j2     <= 1'b0;
      colisao_j1 <= 1'b0;
      colisao_j2 <= 1'b0;
      ram_wren   <= 1'b0;
      if (clear_req) clear_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (clear_pend || clear_req) begin
            state <= LIMPA;
            busy  <= 1'b1;
          end else if (req_j1 || req_j2) begin
            player <= pick_j2 ? J2 : J1;
            lat_x  <= gx;
            lat_y  <= gy;
            cor    <= pick_j2 ? COR_J2 : COR_J1;
            busy   <= 1'b1;
            if (oob) begin
              col_flag <= 1'b1;
              state    <= FIM;
            end else begin
              col_flag      <= 1'b0;
              ram_rdaddress <= rd_addr;
              state         <= LE;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        LIMPA: begin
          ram_wren      <= 1'b1;
          ram_wraddress <= ag_addr;
          ram_data      <= 8'h00;
          if (ag_last) begin
            clear_pend <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        LE:     state <= ESPERA;
        ESPERA: state <= VERIFICA;
        VERIFICA: begin
          if (ram_q != 8'h00) begin
            col_flag <= 1'b1;
            state    <= FIM;
          end else begin
            state <= ESCREVE;
          end
        end
        ESCREVE: begin
          ram_wren      <= 1'b1;
          ram_wraddress <= ag_addr;
          ram_data      <= cor;
          if (ag_last) state <= FIM;
        end
        FIM: begin
          if (player == J2) begin
            ack_j2     <= 1'b1;
            colisao_j2 <= col_flag;
          end else begin
            ack_j1     <= 1'b1;
            colisao_j1 <= col_flag;
          end
          last_srv <= player;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
